magnitude_sqrt: RTL and testbench

//  Streaming integer square root for the power word (I^2+Q^2) produced by the magnitude block.

---
 rtl/magnitude_sqrt_pkg.sv | 30 +++
 rtl/magnitude_sqrt_stage.sv | 90 +++++++++
 rtl/magnitude_sqrt.sv | 109 ++++++++++
 tb/tb_magnitude_sqrt.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/magnitude_sqrt_pkg.sv
// -----------------------------------------------------------------------------
// magnitude_sqrt_pkg
//   Shared widths and the per-stage pipeline record for the streaming integer
//   square root that follows the magnitude block.
//   - sqrt_out_size(): root width for a given radicand width.
//   - SQRT_* constants: widths for the default 16-bit I/Q datapath.
//   - sqrt_stage_t: what every root stage hands to the next one.
// -----------------------------------------------------------------------------
package magnitude_sqrt_pkg;

   function automatic int sqrt_out_size(input int in_size);
      return (in_size + 1) / 2;
   endfunction

   localparam int SQRT_DATA_SIZE = 16;
   localparam int SQRT_IN_SIZE   = 2*SQRT_DATA_SIZE + 1;
   localparam int SQRT_OUT_SIZE  = sqrt_out_size(SQRT_IN_SIZE);
   localparam int SQRT_REM_W     = SQRT_OUT_SIZE + 2;
   localparam int SQRT_RAD_W     = 2*SQRT_OUT_SIZE;

   typedef struct packed {
      logic [SQRT_REM_W-1:0]    rem;
      logic [SQRT_OUT_SIZE-1:0] root;
      logic [SQRT_RAD_W-1:0]    radicand;
      logic                     en;
      logic                     sof;
      logic                     eof;
   } sqrt_stage_t;

endpackage

// File: rtl/magnitude_sqrt_stage.sv
// -----------------------------------------------------------------------------
// magnitude_sqrt_stage
//   One restoring digit-by-digit iteration followed by its pipeline register.
//   Produces one root bit (MSB first) per instance.
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (clears en/sof/eof; data too
//               when RST_DATA is set)
//   prev_stage  record from the previous stage (or the zero-extended input)
//   stage       registered record after this iteration
// Data registers load only when the sample they carry is valid, so the last
// stage holds the most recent result between valid samples.
// -----------------------------------------------------------------------------
module magnitude_sqrt_stage
   import magnitude_sqrt_pkg::*;
#(
   parameter bit RST_DATA = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  sqrt_stage_t prev_stage,
   output sqrt_stage_t stage
);

   localparam int OW = SQRT_OUT_SIZE;
   localparam int RW = SQRT_REM_W;
   localparam int DW = SQRT_RAD_W;

   // The shifted remainder is kept two bits wider than stored; the top bits are
   // always zero in practice but take part in the compare so nothing is dropped.
   logic [RW+1:0] rem_wide;
   logic [RW-1:0] trial;
   logic          take;
   logic [RW-1:0] rem_nxt;
   logic [OW-1:0] root_nxt;
   logic [DW-1:0] rad_nxt;

   always_comb begin
      rem_wide = {prev_stage.rem, prev_stage.radicand[DW-1 -: 2]};
      trial    = {prev_stage.root, 2'b01};
      take     = (rem_wide >= {2'b00, trial});
      rem_nxt  = take ? RW'(rem_wide - {2'b00, trial}) : RW'(rem_wide);
      root_nxt = {prev_stage.root[OW-2:0], take};
      rad_nxt  = {prev_stage.radicand[DW-3:0], 2'b00};
   end

   // ---- stage register ----
   logic          vld_p1, sof_p1, eof_p1;
   logic [RW-1:0] rem_p1;
   logic [OW-1:0] root_p1;
   logic [DW-1:0] rad_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         sof_p1 <= 1'b0;
         eof_p1 <= 1'b0;
      end else begin
         vld_p1 <= prev_stage.en;
         sof_p1 <= prev_stage.sof;
         eof_p1 <= prev_stage.eof;
      end
   end

   if (RST_DATA) begin : g_rst_data
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rem_p1  <= '0;
            root_p1 <= '0;
            rad_p1  <= '0;
         end else if (prev_stage.en) begin
            rem_p1  <= rem_nxt;
            root_p1 <= root_nxt;
            rad_p1  <= rad_nxt;
         end
      end
   end else begin : g_hold_data
      always_ff @(posedge clk) begin
         if (prev_stage.en) begin
            rem_p1  <= rem_nxt;
            root_p1 <= root_nxt;
            rad_p1  <= rad_nxt;
         end
      end
   end

   assign stage = '{rem: rem_p1, root: root_p1, radicand: rad_p1,
                    en: vld_p1, sof: sof_p1, eof: eof_p1};

endmodule

// File: rtl/magnitude_sqrt.sv
// -----------------------------------------------------------------------------
// magnitude_sqrt
//   Streaming integer square root: turns the power word I^2+Q^2 from the
//   magnitude block back into amplitude |I+jQ|. One sample per clock, no
//   backpressure, sof/eof carried with their sample.
// Ports
//   data_clk_i  clock (rising edge)
//   data_rst_i  asynchronous active-low reset
//   data_i      unsigned power, IN_SIZE bits
//   data_en_i   data_i valid
//   data_sof_i  start of frame, qualified by data_en_i
//   data_eof_i  end of frame, qualified by data_en_i
//   data_o      amplitude, OUT_SIZE bits, holds while data_en_o is low
//   data_en_o   one-cycle pulse per input sample
//   data_sof_o  sof of the emerging sample
//   data_eof_o  eof of the emerging sample
// Configuration
//   MAGNITUDE_SQRT_ROUND_EN defined: round to nearest, one extra register,
//   latency OUT_SIZE+1. Undefined: floor root, latency OUT_SIZE.
// The stage record widths come from magnitude_sqrt_pkg, so DATA_SIZE must
// match SQRT_DATA_SIZE there.
// -----------------------------------------------------------------------------
module magnitude_sqrt
   import magnitude_sqrt_pkg::*;
#(
   parameter  int DATA_SIZE = SQRT_DATA_SIZE,
   localparam int IN_SIZE   = 2*DATA_SIZE + 1,
   localparam int OUT_SIZE  = sqrt_out_size(IN_SIZE)
) (
   input  logic                data_clk_i,
   input  logic                data_rst_i,
   input  logic [IN_SIZE-1:0]  data_i,
   input  logic                data_en_i,
   input  logic                data_sof_i,
   input  logic                data_eof_i,
   output logic [OUT_SIZE-1:0] data_o,
   output logic                data_en_o,
   output logic                data_sof_o,
   output logic                data_eof_o
);

`ifdef MAGNITUDE_SQRT_ROUND_EN
   localparam bit LAST_RST = 1'b0;
`else
   // Without the round register the last root stage drives the outputs
   // directly, so it must clear its data on reset.
   localparam bit LAST_RST = 1'b1;
`endif

   sqrt_stage_t chain [0:SQRT_OUT_SIZE];

   // Entry: zero-extend the odd-width radicand to an even number of bits.
   assign chain[0] = '{rem: '0, root: '0, radicand: SQRT_RAD_W'(data_i),
                       en: data_en_i,
                       sof: data_sof_i & data_en_i,
                       eof: data_eof_i & data_en_i};

   for (genvar k = 0; k < SQRT_OUT_SIZE; k++) begin : g_stage
      magnitude_sqrt_stage #(
         .RST_DATA((k == SQRT_OUT_SIZE-1) && LAST_RST)
      ) u_stage (
         .clk        (data_clk_i),
         .rst_n      (data_rst_i),
         .prev_stage (chain[k]),
         .stage      (chain[k+1])
      );
   end

`ifdef MAGNITUDE_SQRT_ROUND_EN
   // Final remainder is N - r^2; rounding up exactly when it exceeds r means
   // N > r^2 + r + 1/4. Integer N never lands on the tie.
   function automatic logic [OUT_SIZE-1:0] round_root(
      input logic [SQRT_OUT_SIZE-1:0] root,
      input logic [SQRT_REM_W-1:0]    rem
   );
      return (rem > {2'b00, root}) ? OUT_SIZE'(root + 1'b1) : OUT_SIZE'(root);
   endfunction

   // ---- round register ----
   logic [OUT_SIZE-1:0] amp_p1;
   logic                vld_p1, sof_p1, eof_p1;

   always_ff @(posedge data_clk_i or negedge data_rst_i) begin
      if (!data_rst_i) begin
         amp_p1 <= '0;
         vld_p1 <= 1'b0;
         sof_p1 <= 1'b0;
         eof_p1 <= 1'b0;
      end else begin
         vld_p1 <= chain[SQRT_OUT_SIZE].en;
         sof_p1 <= chain[SQRT_OUT_SIZE].sof;
         eof_p1 <= chain[SQRT_OUT_SIZE].eof;
         if (chain[SQRT_OUT_SIZE].en)
            amp_p1 <= round_root(chain[SQRT_OUT_SIZE].root, chain[SQRT_OUT_SIZE].rem);
      end
   end

   assign data_o     = amp_p1;
   assign data_en_o  = vld_p1;
   assign data_sof_o = sof_p1;
   assign data_eof_o = eof_p1;
`else
   assign data_o     = OUT_SIZE'(chain[SQRT_OUT_SIZE].root);
   assign data_en_o  = chain[SQRT_OUT_SIZE].en;
   assign data_sof_o = chain[SQRT_OUT_SIZE].sof;
   assign data_eof_o = chain[SQRT_OUT_SIZE].eof;
`endif

endmodule

// File: tb/tb_magnitude_sqrt.sv
// -----------------------------------------------------------------------------
// tb_magnitude_sqrt
//   Self-checking bench for magnitude_sqrt. A cycle-level queue of expected
//   outputs, filled from an arithmetic square-root reference, is compared to
//   the DUT one cycle at a time. Honours MAGNITUDE_SQRT_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_magnitude_sqrt;

   localparam int IN_W  = 33;
   localparam int OUT_W = 17;
`ifdef MAGNITUDE_SQRT_ROUND_EN
   localparam bit ROUND = 1'b1;
   localparam int LAT   = 18;
`else
   localparam bit ROUND = 1'b0;
   localparam int LAT   = 17;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [IN_W-1:0]  din = '0;
   logic             en_in = 1'b0, sof_in = 1'b0, eof_in = 1'b0;
   logic [OUT_W-1:0] dout;
   logic             en_out, sof_out, eof_out;

   always #5 clk = ~clk;

   magnitude_sqrt #(.DATA_SIZE(16)) dut (
      .data_clk_i (clk),
      .data_rst_i (rst_n),
      .data_i     (din),
      .data_en_i  (en_in),
      .data_sof_i (sof_in),
      .data_eof_i (eof_in),
      .data_o     (dout),
      .data_en_o  (en_out),
      .data_sof_o (sof_out),
      .data_eof_o (eof_out)
   );

   typedef struct {
      bit     en;
      bit     sof;
      bit     eof;
      longint val;
   } exp_t;

   exp_t   pipe[$];
   longint held;
   int     n_checks = 0;
   int     n_fail   = 0;
   string  phase    = "reset";

   // Reference amplitude: floor(sqrt(n)) from real arithmetic, corrected to
   // the exact integer root, then rounded to nearest when enabled.
   function automatic longint ref_amp(input longint n);
      longint r;
      r = longint'($sqrt(real'(n)));
      while (r * r > n) r--;
      while ((r + 1) * (r + 1) <= n) r++;
      if (ROUND && (n - r * r > r)) r++;
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_checks++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, want);
      end
   endtask

   // Empty pipeline: LAT-1 idle slots ahead of the next sample, output zero.
   task automatic flush_model();
      exp_t idle;
      idle = '{en: 1'b0, sof: 1'b0, eof: 1'b0, val: 0};
      pipe.delete();
      repeat (LAT - 1) pipe.push_back(idle);
      held = 0;
   endtask

   // Drive one cycle of input, advance one clock, check the outputs.
   // want >= 0 overrides the model with a hand-derived expected amplitude.
   task automatic step(input bit e, input logic [IN_W-1:0] d, input bit s, input bit f,
                       input longint want = -1);
      exp_t x;
      din    = d;
      en_in  = e;
      sof_in = s;
      eof_in = f;
      x.en  = e;
      x.sof = s & e;
      x.eof = f & e;
      x.val = (want >= 0) ? want : ref_amp(longint'(d));
      pipe.push_back(x);
      @(posedge clk);
      #1;
      x = pipe.pop_front();
      if (x.en) held = x.val;
      check({phase, ".en"},   64'(en_out),  64'(x.en));
      check({phase, ".sof"},  64'(sof_out), 64'(x.sof));
      check({phase, ".eof"},  64'(eof_out), 64'(x.eof));
      check({phase, ".data"}, 64'(dout),    64'(held));
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, '0, 1'b0, 1'b0);
   endtask

   function automatic logic [IN_W-1:0] rand_power();
      logic [63:0] w;
      case ($urandom_range(0, 3))
         0:       w = 64'($urandom_range(0, 1000));
         1:       w = 64'h1_FFFF_FFFF - 64'($urandom_range(0, 100000));
         default: w = {$urandom(), $urandom()};
      endcase
      return IN_W'(w);
   endfunction

   initial begin
      int sent;
      int total;

      // Reset state
      flush_model();
      #2;
      check("reset.en",   64'(en_out),  64'd0);
      check("reset.sof",  64'(sof_out), 64'd0);
      check("reset.eof",  64'(eof_out), 64'd0);
      check("reset.data", 64'(dout),    64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: zero input, sof and eof on the same sample
      phase = "t1";
      step(1'b1, '0, 1'b1, 1'b1, 0);
      idle(LAT + 2);

      // T2..T4: boundary values against hand-derived roots
      phase = "t2";
      step(1'b1, 33'd2147483648, 1'b0, 1'b0, ROUND ? 46341 : 46340);
      phase = "t3";
      step(1'b1, 33'h1_FFFF_FFFF, 1'b0, 1'b0, ROUND ? 92682 : 92681);
      phase = "t4";
      step(1'b1, 33'd20, 1'b0, 1'b0, 4);
      step(1'b1, 33'd24, 1'b0, 1'b0, ROUND ? 5 : 4);
      idle(LAT + 2);

      // T5: 1000 random samples with random gaps; sof/eof noise on idle cycles
      phase = "t5";
      sent  = 0;
      total = 1000;
      while (sent < total) begin
         bit e, s, f;
         e = ($urandom_range(0, 3) != 0);
         if (e) begin
            s = (sent == 0);
            f = (sent == total - 1);
            sent++;
         end else begin
            s = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
         end
         step(e, rand_power(), s, f);
      end
      idle(LAT + 2);

      // T6: asynchronous reset with samples in flight
      phase = "t6";
      repeat (10) step(1'b1, rand_power(), 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6.rst_en",   64'(en_out),  64'd0);
      check("t6.rst_sof",  64'(sof_out), 64'd0);
      check("t6.rst_eof",  64'(eof_out), 64'd0);
      check("t6.rst_data", 64'(dout),    64'd0);
      din    = '0;
      en_in  = 1'b0;
      sof_in = 1'b0;
      eof_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      flush_model();
      phase = "t6post";
      idle(LAT + 3);
      step(1'b1, 33'd1000000, 1'b1, 1'b0, 1000);
      idle(LAT + 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
